// File: rtl/pipeline_stall_controller.sv
// ---------------------------------------------------------------------------
// pipeline_stall_controller
//
// Stall/flush sequencer for the classic five-stage pipeline (IF/ID/EX/MEM/WB).
// It merges four hazard sources into one set of pipeline-register controls:
//   - load-use hazards (a single bubble),
//   - taken branches resolved in EX (flush IF/ID, bubble ID/EX),
//   - multi-cycle mul/div issue (MD_LAT stall cycles),
//   - data-memory wait states (whole-pipe freeze).
// A three-state FSM (RUN / MD_WAIT / MEM_WAIT) tracks the two multi-cycle
// cases. While frozen on memory, the FSM remembers the state it came from and
// resumes those rules once the memory completes.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   rs_id, rt_id      source registers of the instruction in ID
//   rt_use_id         ID instruction actually reads rt
//   rt_ex             destination rt of the instruction in EX
//   memread_ex        EX instruction is a load
//   branch_taken_ex   branch/jump in EX resolved taken
//   md_start_id       ID instruction is a mul/div
//   dmem_req          MEM stage is accessing data memory
//   dmem_ready        data memory completes its access this cycle
//   pc_write          PC load enable
//   ifid_write        IF/ID load enable
//   ifid_flush        IF/ID cleared to NOP
//   idex_bubble       ID/EX loaded with NOP
//   pipe_freeze       hold PC, IF/ID, ID/EX, EX/MEM
//   md_done           one-cycle pulse when a mul/div stall is released
//   state             0=RUN 1=MD_WAIT 2=MEM_WAIT
//   stall_cnt         saturating count of cycles with pc_write=0
// ---------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0] rt_id,
  input  logic              rt_use_id,
  input  logic [REG_AW-1:0] rt_ex,
  input  logic              memread_ex,
  input  logic              branch_taken_ex,
  input  logic              md_start_id,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic              pipe_freeze,
  output logic              md_done,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MD_WAIT  = 2'd1;
  localparam logic [1:0] ST_MEM_WAIT = 2'd2;

  // MD_LAT is at most 15, so four bits always hold the remaining count.
  localparam int          MD_W       = 4;
  localparam logic [MD_W-1:0] MD_RELOAD = MD_W'(MD_LAT - 1);

  logic [1:0]       state_q,  state_d;
  logic [1:0]       ret_q,    ret_d;
  logic [MD_W-1:0]  md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] stall_q;

  logic [1:0] eff_state;
  logic       dmem_miss;
  logic       load_use;

  logic pc_write_c, ifid_write_c, ifid_flush_c, idex_bubble_c;
  logic pipe_freeze_c, md_done_c;

  assign dmem_miss = dmem_req & ~dmem_ready;

  // Register 0 is hard-wired to zero, so a load targeting it never creates a
  // real dependency; rt is only compared when the ID instruction reads it.
  assign load_use = memread_ex && (rt_ex != '0) &&
                    ((rs_id == rt_ex) || (rt_use_id && (rt_id == rt_ex)));

  // While waiting on memory, the rules of the interrupted state apply once
  // the access completes.
  assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_bubble_c = 1'b0;
    pipe_freeze_c = 1'b0;
    md_done_c     = 1'b0;
    state_d       = state_q;
    ret_d         = ret_q;
    md_cnt_d      = md_cnt_q;

    if ((state_q == ST_MEM_WAIT) && !dmem_ready) begin
      // Still waiting: everything holds.
      pipe_freeze_c = 1'b1;
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
    end else if ((state_q != ST_MEM_WAIT) && dmem_miss) begin
      // New miss: freeze and remember where to resume; md_cnt is not touched.
      pipe_freeze_c = 1'b1;
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      ret_d         = (state_q == ST_MD_WAIT) ? ST_MD_WAIT : ST_RUN;
      state_d       = ST_MEM_WAIT;
    end else if (eff_state == ST_MD_WAIT) begin
      if (branch_taken_ex) begin
        // The mul/div in ID is on the wrong path: drop it without md_done.
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
        md_cnt_d      = '0;
        state_d       = ST_RUN;
      end else if (md_cnt_q != '0) begin
        pc_write_c    = 1'b0;
        ifid_write_c  = 1'b0;
        idex_bubble_c = 1'b1;
        md_cnt_d      = md_cnt_q - MD_W'(1);
        state_d       = ST_MD_WAIT;
      end else begin
        // Release: the mul/div moves to EX this cycle, so md_start_id (still
        // high for it) must not start another stall.
        md_done_c = 1'b1;
        state_d   = ST_RUN;
      end
    end else begin
      state_d = ST_RUN;
      if (branch_taken_ex) begin
        // ID instruction is squashed, so its mul/div or load-use hazard is moot.
        ifid_flush_c  = 1'b1;
        idex_bubble_c = 1'b1;
      end else if (md_start_id) begin
        pc_write_c    = 1'b0;
        ifid_write_c  = 1'b0;
        idex_bubble_c = 1'b1;
        md_cnt_d      = MD_RELOAD;
        state_d       = ST_MD_WAIT;
      end else if (load_use) begin
        pc_write_c    = 1'b0;
        ifid_write_c  = 1'b0;
        idex_bubble_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      ret_q    <= ST_RUN;
      md_cnt_q <= '0;
      stall_q  <= '0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      md_cnt_q <= md_cnt_d;
      if (!pc_write_c && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
    end
  end

  // During reset the pipeline runs freely with no stall or flush requests.
  assign pc_write    = rst | pc_write_c;
  assign ifid_write  = rst | ifid_write_c;
  assign ifid_flush  = ~rst & ifid_flush_c;
  assign idex_bubble = ~rst & idex_bubble_c;
  assign pipe_freeze = ~rst & pipe_freeze_c;
  assign md_done     = ~rst & md_done_c;
  assign state       = state_q;
  assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller (MD_LAT=4, CNT_W=4 so that
// counter saturation is reachable quickly).
module tb_pipeline_stall_controller;

  localparam int REG_AW = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;

  // Control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble,
  //                        pipe_freeze, md_done}
  localparam logic [5:0] C_NORM  = 6'b110000;
  localparam logic [5:0] C_STALL = 6'b000100;
  localparam logic [5:0] C_FLUSH = 6'b111100;
  localparam logic [5:0] C_FRZ   = 6'b000010;
  localparam logic [5:0] C_DONE  = 6'b110001;

  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_MD  = 2'd1;
  localparam logic [1:0] S_MEM = 2'd2;

  logic              clk = 1'b0;
  logic              rst;
  logic [REG_AW-1:0] rs_id, rt_id, rt_ex;
  logic              rt_use_id, memread_ex, branch_taken_ex, md_start_id;
  logic              dmem_req, dmem_ready;
  logic              pc_write, ifid_write, ifid_flush, idex_bubble;
  logic              pipe_freeze, md_done;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_stall_controller #(
    .REG_AW(REG_AW),
    .MD_LAT(MD_LAT),
    .CNT_W (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rs_id          (rs_id),
    .rt_id          (rt_id),
    .rt_use_id      (rt_use_id),
    .rt_ex          (rt_ex),
    .memread_ex     (memread_ex),
    .branch_taken_ex(branch_taken_ex),
    .md_start_id    (md_start_id),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .pc_write       (pc_write),
    .ifid_write     (ifid_write),
    .ifid_flush     (ifid_flush),
    .idex_bubble    (idex_bubble),
    .pipe_freeze    (pipe_freeze),
    .md_done        (md_done),
    .state          (state),
    .stall_cnt      (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rs_id = '0; rt_id = '0; rt_ex = '0;
    rt_use_id = 1'b0; memread_ex = 1'b0; branch_taken_ex = 1'b0;
    md_start_id = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Checks outputs mid-cycle, after inputs for this cycle have settled.
  task automatic chk(input string tag, input logic [5:0] exp_ctl,
                     input logic [1:0] exp_st, input logic [CNT_W-1:0] exp_cnt);
    logic [5:0] ctl;
    #1;
    ctl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze, md_done};
    n_checks++;
    assert (ctl === exp_ctl) else begin
      n_errors++;
      $error("FAIL %s ctl observed=%b expected=%b", tag, ctl, exp_ctl);
    end
    n_checks++;
    assert (state === exp_st) else begin
      n_errors++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, state, exp_st);
    end
    n_checks++;
    assert (stall_cnt === exp_cnt) else begin
      n_errors++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt, exp_cnt);
    end
  endtask

  initial begin
    clr();
    rst = 1'b1;
    cyc();
    // Reset masks a pending mul/div request.
    md_start_id = 1'b1;
    chk("reset", C_NORM, S_RUN, 4'd0);
    cyc();
    rst = 1'b0; clr();
    chk("idle", C_NORM, S_RUN, 4'd0);
    cyc();

    // Load-use: lw $5 in EX, ID reads rs=5 -> one bubble.
    memread_ex = 1'b1; rt_ex = 5'd5; rs_id = 5'd5;
    chk("load_use_rs", C_STALL, S_RUN, 4'd0);
    cyc();
    clr();
    chk("after_load_use", C_NORM, S_RUN, 4'd1);
    cyc();
    // Load into $0 never stalls.
    memread_ex = 1'b1; rt_ex = 5'd0; rs_id = 5'd0;
    chk("load_r0", C_NORM, S_RUN, 4'd1);
    cyc();
    // rt match ignored when rt is not read, honoured when it is.
    memread_ex = 1'b1; rt_ex = 5'd5; rs_id = 5'd3; rt_id = 5'd5; rt_use_id = 1'b0;
    chk("rt_masked", C_NORM, S_RUN, 4'd1);
    rt_use_id = 1'b1;
    chk("load_use_rt", C_STALL, S_RUN, 4'd1);
    cyc();

    // mul at T: stall T..T+3, md_done at T+4.
    clr(); md_start_id = 1'b1;
    chk("md_T0", C_STALL, S_RUN, 4'd2);
    cyc();
    chk("md_T1", C_STALL, S_MD, 4'd3);
    cyc();
    chk("md_T2", C_STALL, S_MD, 4'd4);
    cyc();
    chk("md_T3", C_STALL, S_MD, 4'd5);
    cyc();
    chk("md_T4_done", C_DONE, S_MD, 4'd6);
    cyc();
    clr();
    chk("md_T5_run", C_NORM, S_RUN, 4'd6);
    cyc();

    // Branch taken at T+2 aborts the mul/div stall.
    md_start_id = 1'b1;
    chk("abort_T0", C_STALL, S_RUN, 4'd6);
    cyc();
    chk("abort_T1", C_STALL, S_MD, 4'd7);
    cyc();
    branch_taken_ex = 1'b1;
    chk("abort_T2_flush", C_FLUSH, S_MD, 4'd8);
    cyc();
    clr();
    chk("abort_T3_run", C_NORM, S_RUN, 4'd8);
    cyc();
    chk("abort_T4_no_done", C_NORM, S_RUN, 4'd8);
    cyc();

    // Memory miss for 3 cycles while MD_WAIT has 2 cycles remaining.
    md_start_id = 1'b1;
    chk("mdmem_T0", C_STALL, S_RUN, 4'd8);
    cyc();
    md_start_id = 1'b0;
    chk("mdmem_T1", C_STALL, S_MD, 4'd9);
    cyc();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    chk("mdmem_miss1", C_FRZ, S_MD, 4'd10);
    cyc();
    chk("mdmem_miss2", C_FRZ, S_MEM, 4'd11);
    cyc();
    chk("mdmem_miss3", C_FRZ, S_MEM, 4'd12);
    cyc();
    dmem_ready = 1'b1;
    chk("mdmem_resume_cnt2", C_STALL, S_MEM, 4'd13);
    cyc();
    clr();
    chk("mdmem_cnt1", C_STALL, S_MD, 4'd14);
    cyc();
    chk("mdmem_done", C_DONE, S_MD, 4'd15);
    cyc();

    // Counter saturates at all-ones.
    memread_ex = 1'b1; rt_ex = 5'd7; rs_id = 5'd7;
    chk("sat_stall", C_STALL, S_RUN, 4'd15);
    cyc();
    clr();
    chk("sat_hold", C_NORM, S_RUN, 4'd15);
    cyc();

    // Miss from RUN, then a taken branch on the completion cycle.
    dmem_req = 1'b1; dmem_ready = 1'b0;
    chk("run_miss", C_FRZ, S_RUN, 4'd15);
    cyc();
    dmem_ready = 1'b1; branch_taken_ex = 1'b1;
    chk("mem_ready_branch", C_FLUSH, S_MEM, 4'd15);
    cyc();
    clr();
    chk("mem_back_run", C_NORM, S_RUN, 4'd15);
    cyc();

    // Reset asserted in the middle of MD_WAIT.
    md_start_id = 1'b1;
    chk("rstmd_T0", C_STALL, S_RUN, 4'd15);
    cyc();
    chk("rstmd_T1", C_STALL, S_MD, 4'd15);
    rst = 1'b1;
    chk("rstmd_in_reset", C_NORM, S_MD, 4'd15);
    cyc();
    rst = 1'b0; clr();
    chk("rstmd_after", C_NORM, S_RUN, 4'd0);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
